// File: rtl/snake_tick_ctrl.sv
// snake_tick_ctrl
//   Paces and steers snake_core. The block emits a one-cycle Step pulse per
//   game tick and holds a committed direction Dir between ticks. It detects
//   rising edges on the four direction buttons and rejects 180-degree
//   reversals. It buffers one pending turn, shortens the tick period as the
//   snake grows, and sequences IDLE/RUN/PAUSED/HALT.
//
// Ports
//   Clk        system clock
//   Reset      asynchronous, active-high
//   Left/Right/Up/Down  button levels, already synchronised to Clk
//   Start      start request (rising edge is the event)
//   Pause      pause toggle (rising edge is the event)
//   Game_Over  high while snake_core is in WIN or LOSE
//   Length     current snake length
//   Step       one-cycle pulse: advance the core by one move
//   Dir        committed direction: 00 L, 01 R, 10 U, 11 D
//   Running    state == RUN
//   Paused     state == PAUSED
module snake_tick_ctrl #(
  parameter int CNT_W       = 24,
  parameter int BASE_PERIOD = 5_000_000,
  parameter int SPEEDUP     = 250_000,
  parameter int MIN_PERIOD  = 1_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Left,
  input  logic       Right,
  input  logic       Up,
  input  logic       Down,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Game_Over,
  input  logic [3:0] Length,
  output logic       Step,
  output logic [1:0] Dir,
  output logic       Running,
  output logic       Paused
);

  localparam int PW = CNT_W + 4;
  localparam logic [1:0] DIR_RIGHT = 2'b01;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, HALT} state_t;

  state_t           state, state_next;
  logic [5:0]       hist;
  logic [5:0]       btn_now;
  logic [5:0]       ev;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic             pend_vld;
  logic [1:0]       pend;
  logic             cand_vld;
  logic [1:0]       cand;
  logic             accept;
  logic             expire;

  // The period shrinks with Length and saturates at MIN_PERIOD. The
  // comparison is done before the subtraction so that the result never wraps.
  function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] len);
    logic [PW-1:0] prod;
    logic [PW-1:0] base;
    logic [PW-1:0] minp;
    prod = PW'(len) * PW'(SPEEDUP);
    base = PW'(BASE_PERIOD);
    minp = PW'(MIN_PERIOD);
    if (prod >= base || (base - prod) < minp)
      return CNT_W'(MIN_PERIOD);
    else
      return CNT_W'(base - prod);
  endfunction

  // Edge detect: bit order is {L, R, U, D, Start, Pause}
  assign btn_now = {Left, Right, Up, Down, Start, Pause};
  assign ev      = btn_now & ~hist;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) hist <= '0;
    else       hist <= btn_now;
  end

  // Fixed priority L > R > U > D; only the winner is judged
  always_comb begin
    cand_vld = 1'b1;
    cand     = 2'b00;
    if      (ev[5]) cand = 2'b00;
    else if (ev[4]) cand = 2'b01;
    else if (ev[3]) cand = 2'b10;
    else if (ev[2]) cand = 2'b11;
    else            cand_vld = 1'b0;
  end

  // Opposites differ only in the low bit (L/R = 0x, U/D = 1x)
  assign accept = cand_vld && (state == RUN || state == PAUSED) &&
                  (cand != {Dir[1], ~Dir[0]});

  assign expire = (cnt == period - CNT_W'(1));

  // FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // Game_Over outranks both Pause and tick expiry, so Step is gated here too
  always_comb begin
    state_next = state;
    Step       = 1'b0;
    Running    = 1'b0;
    Paused     = 1'b0;
    case (state)
      IDLE:   if (ev[1]) state_next = RUN;
      RUN: begin
        Running = 1'b1;
        if (Game_Over) state_next = HALT;
        else begin
          Step = expire;
          if (ev[0]) state_next = PAUSED;
        end
      end
      PAUSED: begin
        Paused = 1'b1;
        if (Game_Over)  state_next = HALT;
        else if (ev[0]) state_next = RUN;
      end
      HALT:   if (!Game_Over) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tick counter and period latch. A pause edge freezes the counter in the
  // same cycle, so resuming continues from the value seen at the pause.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt    <= '0;
      period <= CNT_W'(BASE_PERIOD);
    end else if (state == IDLE && ev[1]) begin
      cnt    <= '0;
      period <= calc_period(Length);
    end else if (Step) begin
      cnt    <= '0;
      period <= calc_period(Length);
    end else if (state == RUN && !Game_Over && !ev[0]) begin
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // A press accepted in the Step cycle is judged against the old Dir. It
  // lands in pending after the commit, so the press waits for the next tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Dir      <= DIR_RIGHT;
      pend     <= 2'b00;
      pend_vld <= 1'b0;
    end else if (state == HALT && !Game_Over) begin
      Dir      <= DIR_RIGHT;
      pend_vld <= 1'b0;
    end else begin
      if (Step) begin
        if (pend_vld) Dir <= pend;
        pend_vld <= 1'b0;
      end
      if (accept) begin
        pend     <= cand;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snake_tick_ctrl.sv
module tb_snake_tick_ctrl;

  localparam int CNT_W = 8;
  localparam int BASE  = 20;
  localparam int SPD   = 2;
  localparam int MINP  = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Left, Right, Up, Down, Start, Pause, Game_Over;
  logic [3:0] Length;
  logic       Step;
  logic [1:0] Dir;
  logic       Running, Paused;

  snake_tick_ctrl #(
    .CNT_W(CNT_W), .BASE_PERIOD(BASE), .SPEEDUP(SPD), .MIN_PERIOD(MINP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Left(Left), .Right(Right), .Up(Up), .Down(Down),
    .Start(Start), .Pause(Pause), .Game_Over(Game_Over), .Length(Length),
    .Step(Step), .Dir(Dir), .Running(Running), .Paused(Paused)
  );

  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: game phase, cycles left until the next tick, direction
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_HALT = 3;
  int         m_mode;
  int         left;
  logic [1:0] m_dir;
  bit         p_valid;
  logic [1:0] p_dir;
  logic [5:0] hist;
  bit         saw_step;

  function automatic int period_of(input int len);
    int p;
    p = BASE - len * SPD;
    return (p < MINP) ? MINP : p;
  endfunction

  function automatic logic [1:0] opposite(input logic [1:0] d);
    case (d)
      2'd0:    return 2'd1;
      2'd1:    return 2'd0;
      2'd2:    return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic model_reset();
    m_mode  = M_IDLE;
    left    = 0;
    m_dir   = 2'b01;
    p_valid = 1'b0;
    p_dir   = 2'b00;
    hist    = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set (at posedge+1); outputs are
  // sampled mid-cycle, then the model advances to the next cycle.
  task automatic tick();
    logic [5:0] now, ev;
    logic [1:0] cand;
    bit         has_cand, acc, go, e_step;
    @(negedge Clk);
    #1;
    now    = {Left, Right, Up, Down, Start, Pause};
    ev     = now & ~hist;
    go     = Game_Over;
    e_step = (m_mode == M_RUN) && (left == 1) && !go;
    saw_step = Step;
    check("step",    32'(Step),    32'(e_step));
    check("dir",     32'(Dir),     32'(m_dir));
    check("running", 32'(Running), 32'(m_mode == M_RUN));
    check("paused",  32'(Paused),  32'(m_mode == M_PAUSED));

    has_cand = 1'b1;
    cand     = 2'd0;
    if      (ev[5]) cand = 2'd0;
    else if (ev[4]) cand = 2'd1;
    else if (ev[3]) cand = 2'd2;
    else if (ev[2]) cand = 2'd3;
    else            has_cand = 1'b0;
    acc = has_cand && (m_mode == M_RUN || m_mode == M_PAUSED) && (cand != opposite(m_dir));

    if (e_step) begin
      if (p_valid) m_dir = p_dir;
      p_valid = 1'b0;
    end
    if (acc) begin
      p_dir   = cand;
      p_valid = 1'b1;
    end

    case (m_mode)
      M_IDLE: if (ev[1]) begin m_mode = M_RUN; left = period_of(int'(Length)); end
      M_RUN: begin
        if (go) m_mode = M_HALT;
        else begin
          if (e_step)      left = period_of(int'(Length));
          else if (!ev[0]) left = left - 1;
          if (ev[0]) m_mode = M_PAUSED;
        end
      end
      M_PAUSED: begin
        if (go)         m_mode = M_HALT;
        else if (ev[0]) m_mode = M_RUN;
      end
      default: if (!go) begin m_mode = M_IDLE; m_dir = 2'b01; p_valid = 1'b0; end
    endcase
    hist = now;
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_step(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!saw_step && n < 200);
  endtask

  task automatic advance_to(input int want_left);
    int g;
    g = 0;
    while (!(m_mode == M_RUN && left == want_left) && g < 500) begin
      tick();
      g++;
    end
    check("advance_bound", 32'(g < 500), 32'(1));
  endtask

  initial begin
    int n, sc;
    Reset = 1'b1;
    {Left, Right, Up, Down, Start, Pause, Game_Over} = '0;
    Length = 4'd0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_step", 32'(Step), 32'(0));
    check("rst_dir",  32'(Dir),  32'(1));
    check("rst_run",  32'(Running), 32'(0));
    check("rst_pause", 32'(Paused), 32'(0));
    Reset = 1'b0;
    tick();

    // Basic pacing
    Start = 1'b1; tick(); Start = 1'b0;
    wait_step(n); check("first_interval", 32'(n), 32'(20));
    wait_step(n); check("interval_20", 32'(n), 32'(20));

    // Speed-up and saturation
    Length = 4'd3;
    wait_step(n); check("interval_pre3", 32'(n), 32'(20));
    wait_step(n); check("interval_len3", 32'(n), 32'(14));
    Length = 4'd15;
    wait_step(n); check("interval_pre15", 32'(n), 32'(14));
    wait_step(n); check("interval_sat", 32'(n), 32'(8));
    Length = 4'd0;
    wait_step(n); check("interval_back", 32'(n), 32'(8));
    wait_step(n); check("interval_20b", 32'(n), 32'(20));

    // Reversal rejection and last-press-wins
    Left = 1'b1; tick(); Left = 1'b0;
    wait_step(n); check("reverse_rejected", 32'(Dir), 32'(1));
    Up = 1'b1; tick(); Up = 1'b0;
    Left = 1'b1; tick(); Left = 1'b0;
    wait_step(n); check("up_commits", 32'(Dir), 32'(2));
    Down = 1'b1; tick(); Down = 1'b0;
    wait_step(n); check("down_rejected", 32'(Dir), 32'(2));

    // Press in the Step cycle is deferred one tick
    Left = 1'b1; tick(); Left = 1'b0;
    wait_step(n); check("left_commits", 32'(Dir), 32'(0));
    advance_to(1);
    Up = 1'b1; tick(); Up = 1'b0;
    check("same_cycle_deferred", 32'(Dir), 32'(0));
    wait_step(n); check("same_cycle_later", 32'(Dir), 32'(2));
    Left = 1'b1; Down = 1'b1; tick(); Left = 1'b0; Down = 1'b0;
    wait_step(n); check("left_priority", 32'(Dir), 32'(0));

    // Pause / resume, then Game_Over in the expiry cycle
    advance_to(13);
    Pause = 1'b1; tick(); Pause = 1'b0;
    sc = 0;
    repeat (100) begin tick(); sc += int'(saw_step); end
    check("paused_no_step", 32'(sc), 32'(0));
    Pause = 1'b1; tick(); Pause = 1'b0;
    wait_step(n); check("resume_interval", 32'(n), 32'(13));
    advance_to(1);
    Game_Over = 1'b1; tick();
    check("halt_running", 32'(Running), 32'(0));
    check("halt_paused", 32'(Paused), 32'(0));
    Game_Over = 1'b0; tick();
    check("idle_dir_right", 32'(Dir), 32'(1));

    // Reset during a Step cycle with a pending turn
    Start = 1'b1; tick(); Start = 1'b0;
    Up = 1'b1; tick(); Up = 1'b0;
    advance_to(1);
    check("pre_reset_step", 32'(Step), 32'(1));
    Reset = 1'b1;
    #1;
    check("mid_rst_step", 32'(Step), 32'(0));
    check("mid_rst_dir", 32'(Dir), 32'(1));
    check("mid_rst_run", 32'(Running), 32'(0));
    check("mid_rst_pause", 32'(Paused), 32'(0));
    model_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    sc = 0;
    repeat (60) begin tick(); sc += int'(saw_step); end
    check("no_step_after_reset", 32'(sc), 32'(0));
    Start = 1'b1; tick(); Start = 1'b0;
    wait_step(n); check("restart_interval", 32'(n), 32'(20));
    check("pending_cleared", 32'(Dir), 32'(1));

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      Left  = ($urandom_range(0, 5) == 0);
      Right = ($urandom_range(0, 5) == 0);
      Up    = ($urandom_range(0, 5) == 0);
      Down  = ($urandom_range(0, 5) == 0);
      Start = ($urandom_range(0, 29) == 0);
      Pause = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 149) == 0) Game_Over = ~Game_Over;
      if ($urandom_range(0, 39) == 0) Length = 4'($urandom_range(0, 15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
